riscv_core: RTL and testbench
=============================

Name: riscv_core

Overview:
- Single-issue RV32I integer core with a 2-stage pipeline (IF, EX/WB), a bimodal branch predictor and on-chip instruction/data memories.
- Top-level compute block of the processor; runs a preloaded program until the terminating instruction `jal x0,0` (0x0000006F).
- Exposes PC, last written value, predictor statistics, the full register file and a completion flag for observation.

Parameters:
- IMEM_WORDS, 1024, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 1024, data RAM depth in 32-bit words.
- IMEM_INIT, "program.mem", hex file loaded into the ROM at elaboration.
- BHT_ENTRIES, 64, predictor table entries (power of 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous, active-high reset (rstn=1 resets).
- stall  in  1  1 = freeze all state this cycle.
- bp_disable  in  1  1 = predictor forced to predict not-taken; table still trains.
- pc  out  32  current fetch PC.
- rd  out  32  data of the latest register write with rd!=x0.
- preds  out  3x32  [0] conditional branches resolved, [1] correctly predicted, [2] mispredicted.
- regs  out  32x32  architectural register file; regs[0] is always 0.
- completed  out  1  sticky; set when EX executes 0x0000006F.

Behaviour:
- Reset values (clock edge with rstn=1):
  - pc=0, all regs=0, rd=0, preds all 0, completed=0.
  - IF/EX register holds a bubble (NOP).
  - All BHT counters set to 01 (weakly not-taken).
- Supported ISA: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
- Any other opcode executes as a NOP.
- Writes to x0 are ignored.
- Memories are byte-addressed, little-endian; both are read combinationally.
  - IMEM index = pc[31:2] mod IMEM_WORDS.
  - DMEM index = addr[31:2] mod DMEM_WORDS.
  - DMEM writes use byte enables and take effect on the clock edge.
- Misaligned accesses use the aligned word and select byte/half by addr[1:0]; halfword at addr[1:0]=3 is undefined.
- IF stage:
  - Predecodes the fetched instruction.
  - JAL: next pc = pc+imm (no penalty, not counted in preds).
  - Conditional branch: indexes the BHT with pc[log2(BHT_ENTRIES)+1:2]. If counter[1]=1 and bp_disable=0, next pc = pc+imm; otherwise pc+4.
  - All others: pc+4.
  - IF/EX register latches instr, pc and the predicted-taken bit.
- EX stage:
  - Reads the register file, executes, and writes back the register file and DMEM in the same cycle, so there are no data hazards.
  - Conditional branches increment preds[0] and one of preds[1]/preds[2].
  - The BHT counter saturates toward the actual outcome (00..11).
  - Mispredict: IF/EX becomes a bubble and pc is loaded with the correct target (taken: pc+imm; not taken: pc+4). Penalty is 1 cycle.
  - JALR: always 1 bubble; pc = (rs1+imm)&~1; writes rd with pc+4.
- Shifts use rs2[4:0]/shamt. SLT compares signed, SLTU unsigned. Arithmetic wraps modulo 2^32.
- Completion: when EX holds 0x0000006F, completed is set. From the next edge on, no state changes except by reset.
- stall=1: pc, IF/EX, regs, DMEM, BHT, counters and completed all hold.
- Reset has priority over stall and completed; reset mid-program restarts from pc=0 with cleared state.
  - DMEM contents are not cleared by reset.
  - IMEM is never written.

Decomposition:
- Package riscv_pkg: opcode/funct3/funct7 constants, ALU op enum, immediate-type enum, BHT counter type.
- One natural sub-module: riscv_alu (op, a, b -> result, branch condition).
- Predictor, regfile and memories stay inline in riscv_core.

Test Plan:
- Reset: hold rstn=1 for 2 cycles -> pc=0, regs all 0, rd=0, preds={0,0,0}, completed=0.
- Straight-line: `addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; jal x0,0` -> regs[3]=12, rd=12, completed=1 within 6 cycles of reset release; pc then constant.
- Loop: `addi x1,x0,10; L: addi x1,x1,-1; bne x1,x0,L; jal x0,0` -> x1=0, preds={10,8,2}.
- Same loop with bp_disable=1 -> preds={10,1,9}, x1=0.
- Memory: `addi x1,x0,-128; sb x1,3(x0); lb x2,3(x0); lbu x3,3(x0); lw x4,0(x0)` -> x2=-128, x3=128, x4=0x80000000; `addi x0,x0,5` leaves regs[0]=0.
- Stall: assert stall for 5 cycles mid-loop -> pc/regs/preds frozen during stall; final results identical to the unstalled run.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, ALU/immediate enums and predictor counter type.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] INSTR_HALT = 32'h0000_006F;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // funct7 value that selects SUB/SRA (only bit 30 differs from zero)
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_INIT = 2'b01;

    // Sign-extended immediate; the opcode field is not needed, so only [31:7] is passed.
    function automatic logic [31:0] imm_gen(input logic [31:7] ins, input imm_type_e t);
        case (t)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // funct3 plus the alternate bit (instr[30]) to ALU operation.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Integer ALU plus conditional-branch comparator.
module riscv_alu
    import riscv_pkg::*;
(
    input  alu_op_e     op,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        cond
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // Arithmetic/logic result, wrapping modulo 2^32.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, a_s < b_s};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = a_s >>> b[4:0];
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    // Branch condition selected by the branch funct3.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (a == b);
            F3_BNE:  cond = (a != b);
            F3_BLT:  cond = (a_s < b_s);
            F3_BGE:  cond = (a_s >= b_s);
            F3_BLTU: cond = (a < b);
            F3_BGEU: cond = (a >= b);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_core.sv
// RV32I core: IF (fetch + bimodal prediction) and EX/WB stages, inline ROM/RAM/regfile/BHT.
module riscv_core
    import riscv_pkg::*;
#(
    parameter int    IMEM_WORDS  = 1024,
    parameter int    DMEM_WORDS  = 1024,
    parameter string IMEM_INIT   = "program.mem",
    parameter int    BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        bp_disable,
    output logic [31:0] pc,
    output logic [31:0] rd,
    output logic [31:0] preds [3],
    output logic [31:0] regs [32],
    output logic        completed
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);
    localparam int BW = $clog2(BHT_ENTRIES);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    bht_ctr_t    bht  [BHT_ENTRIES];

    function automatic bht_ctr_t sat_update(input bht_ctr_t c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic advance;
    assign advance = !rstn && !stall && !completed;

    // ---- IF stage (p0): fetch, predecode, predict ----
    logic [IW-1:0] if_idx;
    logic [31:0]   if_instr;
    logic          if_pred;
    logic [31:0]   if_next_pc;

    assign if_idx   = IW'({2'b00, pc[31:2]} % 32'(IMEM_WORDS));
    assign if_instr = imem[if_idx];
    assign if_pred  = (if_instr[6:0] == OP_BRANCH) && bht[pc[BW+1:2]][1] && !bp_disable;

    always_comb begin
        if_next_pc = pc + 32'd4;
        if (if_instr[6:0] == OP_JAL)
            if_next_pc = pc + imm_gen(if_instr[31:7], IMM_J);
        else if (if_pred)
            if_next_pc = pc + imm_gen(if_instr[31:7], IMM_B);
    end

    // ---- IF/EX boundary (p1) ----
    logic        vld_p1;
    logic        pred_p1;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;

    // ---- EX/WB stage ----
    logic [31:0]   ex_ins;
    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic [4:0]    rd_idx;
    logic [31:0]   rs1_val, rs2_val;
    logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
    alu_op_e       alu_op;
    logic [31:0]   alu_b, alu_res;
    logic          alu_cond;
    logic [31:0]   mem_addr;
    logic [DW-1:0] d_idx;
    logic [31:0]   load_shift;
    logic          wb_en, redirect, is_branch, mem_we;
    logic [31:0]   wb_data, redirect_pc, mem_wdata;
    logic [3:0]    mem_be;

    assign ex_ins   = vld_p1 ? instr_p1 : INSTR_NOP;
    assign opcode   = ex_ins[6:0];
    assign f3       = ex_ins[14:12];
    assign rd_idx   = ex_ins[11:7];
    assign rs1_val  = regs[ex_ins[19:15]];
    assign rs2_val  = regs[ex_ins[24:20]];
    assign imm_i    = imm_gen(ex_ins[31:7], IMM_I);
    assign imm_s    = imm_gen(ex_ins[31:7], IMM_S);
    assign imm_b    = imm_gen(ex_ins[31:7], IMM_B);
    assign imm_u    = imm_gen(ex_ins[31:7], IMM_U);
    assign imm_j    = imm_gen(ex_ins[31:7], IMM_J);
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign d_idx    = DW'({2'b00, mem_addr[31:2]} % 32'(DMEM_WORDS));
    assign load_shift = dmem[d_idx] >> {mem_addr[1:0], 3'b000};

    // ALU operand/operation select; SUB/SRA only when instr[30] is meaningful.
    always_comb begin
        alu_b  = (opcode == OP_IMM) ? imm_i : rs2_val;
        alu_op = alu_decode(f3, ex_ins[30] && ((opcode == OP_OP && ex_ins[31:25] == F7_ALT) || f3 == F3_SR));
    end

    riscv_alu u_alu (
        .op     (alu_op),
        .funct3 (f3),
        .a      (rs1_val),
        .b      (alu_b),
        .result (alu_res),
        .cond   (alu_cond)
    );

    // Execute: writeback value, store lanes and pc redirect.
    always_comb begin
        wb_en       = 1'b0;
        wb_data     = alu_res;
        redirect    = 1'b0;
        redirect_pc = pc_p1 + 32'd4;
        is_branch   = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        mem_wdata   = rs2_val;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_data = pc_p1 + imm_u; end
            OP_JAL:   begin wb_en = 1'b1; wb_data = pc_p1 + 32'd4; end
            OP_JALR: begin
                wb_en       = 1'b1;
                wb_data     = pc_p1 + 32'd4;
                redirect    = 1'b1;
                redirect_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                redirect  = (alu_cond != pred_p1);
                if (alu_cond) redirect_pc = pc_p1 + imm_b;
            end
            OP_LOAD: begin
                wb_en = 1'b1;
                case (f3)
                    F3_B:    wb_data = {{24{load_shift[7]}}, load_shift[7:0]};
                    F3_H:    wb_data = {{16{load_shift[15]}}, load_shift[15:0]};
                    F3_BU:   wb_data = {24'b0, load_shift[7:0]};
                    F3_HU:   wb_data = {16'b0, load_shift[15:0]};
                    default: wb_data = dmem[d_idx];
                endcase
            end
            OP_STORE: begin
                mem_we = 1'b1;
                case (f3)
                    F3_B: begin mem_be = 4'b0001 << mem_addr[1:0]; mem_wdata = {4{rs2_val[7:0]}}; end
                    F3_H: begin mem_be = 4'b0011 << mem_addr[1:0]; mem_wdata = {2{rs2_val[15:0]}}; end
                    default: mem_be = 4'b1111;
                endcase
            end
            OP_IMM, OP_OP: wb_en = 1'b1;
            default: ;
        endcase
    end

    // PC and IF/EX control: redirect injects a bubble, otherwise take the prediction.
    always_ff @(posedge clk) begin
        if (rstn) begin
            pc      <= '0;
            vld_p1  <= 1'b0;
            pred_p1 <= 1'b0;
        end else if (advance) begin
            pc      <= redirect ? redirect_pc : if_next_pc;
            vld_p1  <= !redirect;
            pred_p1 <= !redirect && if_pred;
        end
    end

    // IF/EX data payload; meaningful only while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (advance && !redirect) begin
            instr_p1 <= if_instr;
            pc_p1    <= pc;
        end
    end

    // Register file and last-written value.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            rd <= '0;
        end else if (advance && wb_en && rd_idx != 5'd0) begin
            regs[rd_idx] <= wb_data;
            rd           <= wb_data;
        end
    end

    // Data RAM byte-enable writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (advance && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) dmem[d_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Predictor training toward the resolved outcome.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_INIT;
        end else if (advance && is_branch) begin
            bht[pc_p1[BW+1:2]] <= sat_update(bht[pc_p1[BW+1:2]], alu_cond);
        end
    end

    // Branch statistics and sticky completion flag.
    always_ff @(posedge clk) begin
        if (rstn) begin
            preds[0]  <= '0;
            preds[1]  <= '0;
            preds[2]  <= '0;
            completed <= 1'b0;
        end else if (advance) begin
            if (is_branch) begin
                preds[0] <= preds[0] + 32'd1;
                if (redirect) preds[2] <= preds[2] + 32'd1;
                else          preds[1] <= preds[1] + 32'd1;
            end
            if (ex_ins == INSTR_HALT) completed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: straight-line, loop (predictor on/off), memory, stall, reset.
module tb_riscv_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        bp_disable;
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] preds [3];
    logic [31:0] regs [32];
    logic        completed;

    int n_chk  = 0;
    int n_pass = 0;
    int cycles;
    logic [31:0] prog [$];
    logic [31:0] any_reg;

    riscv_core #(.IMEM_INIT("")) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .bp_disable (bp_disable),
        .pc         (pc),
        .rd         (rd),
        .preds      (preds),
        .regs       (regs),
        .completed  (completed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) begin
            dut.imem[i] = 32'h0;
            dut.dmem[i] = 32'h0;
        end
        for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_done(input string tag);
        rstn   = 1'b0;
        cycles = 0;
        while (!completed && cycles < 500) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_done"}, {31'b0, completed}, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rstn = 1'b1; stall = 1'b0; bp_disable = 1'b0;

        // Straight-line program; reset state checked first.
        prog = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h0000006F};
        load_prog();
        do_reset();
        any_reg = '0;
        for (int i = 0; i < 32; i++) any_reg |= regs[i];
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_regs", any_reg, 32'd0);
        check_eq("rst_rd", rd, 32'd0);
        check_eq("rst_preds0", preds[0], 32'd0);
        check_eq("rst_preds1", preds[1], 32'd0);
        check_eq("rst_preds2", preds[2], 32'd0);
        check_eq("rst_completed", {31'b0, completed}, 32'd0);
        run_done("sl");
        check_eq("sl_latency", {31'b0, cycles <= 6}, 32'd1);
        check_eq("sl_x3", regs[3], 32'd12);
        check_eq("sl_rd", rd, 32'd12);
        step(3);
        check_eq("sl_pc_hold", pc, 32'd12);

        // Countdown loop with predictor enabled.
        prog = '{32'h00A00093, 32'hFFF08093, 32'hFE009EE3, 32'h0000006F};
        load_prog();
        do_reset();
        run_done("loop");
        check_eq("loop_x1", regs[1], 32'd0);
        check_eq("loop_p0", preds[0], 32'd10);
        check_eq("loop_p1", preds[1], 32'd8);
        check_eq("loop_p2", preds[2], 32'd2);

        // Same loop, predictor forced not-taken.
        bp_disable = 1'b1;
        do_reset();
        run_done("nobp");
        check_eq("nobp_x1", regs[1], 32'd0);
        check_eq("nobp_p0", preds[0], 32'd10);
        check_eq("nobp_p1", preds[1], 32'd1);
        check_eq("nobp_p2", preds[2], 32'd9);
        bp_disable = 1'b0;

        // Stall mid-loop: after 8 cycles pc=4, x1=7, preds={2,1,1}; must hold 5 stalled cycles.
        do_reset();
        rstn = 1'b0;
        step(8);
        stall = 1'b1;
        step(5);
        check_eq("stall_pc", pc, 32'd4);
        check_eq("stall_x1", regs[1], 32'd7);
        check_eq("stall_p0", preds[0], 32'd2);
        check_eq("stall_p1", preds[1], 32'd1);
        check_eq("stall_p2", preds[2], 32'd1);
        stall = 1'b0;
        run_done("stall");
        check_eq("stall_end_x1", regs[1], 32'd0);
        check_eq("stall_end_p0", preds[0], 32'd10);
        check_eq("stall_end_p1", preds[1], 32'd8);
        check_eq("stall_end_p2", preds[2], 32'd2);

        // Byte store, signed/unsigned byte loads, word load, write to x0.
        prog = '{32'hF8000093, 32'h001001A3, 32'h00300103, 32'h00304183,
                 32'h00002203, 32'h00500013, 32'h0000006F};
        load_prog();
        do_reset();
        run_done("mem");
        check_eq("mem_x1", regs[1], 32'hFFFFFF80);
        check_eq("mem_lb", regs[2], 32'hFFFFFF80);
        check_eq("mem_lbu", regs[3], 32'h00000080);
        check_eq("mem_lw", regs[4], 32'h80000000);
        check_eq("mem_x0", regs[0], 32'd0);
        check_eq("mem_rd", rd, 32'h80000000);

        // Reset after completion clears architectural state.
        do_reset();
        check_eq("rerst_pc", pc, 32'd0);
        check_eq("rerst_x4", regs[4], 32'd0);
        check_eq("rerst_rd", rd, 32'd0);
        check_eq("rerst_completed", {31'b0, completed}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
